// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared definitions for the keypad scanner: width helpers and FSM encoding.
// Constant functions only; nothing here generates logic.
package keypad_matrix_scanner_pkg;

  typedef enum logic {
    SCAN = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so a one-bit field always exists.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

  // An event is the key code plus one release flag.
  function automatic int evt_width(input int code_w);
    return code_w + 1;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Show-ahead synchronous FIFO: head visible one cycle after a push into empty.
// A push while full is only accepted when a pop happens in the same cycle.
module keypad_event_fifo
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == DEPTH_C);
  assign do_pop   = pop_rdy & ~empty;
  assign do_push  = push_vld & (~full | do_pop);
  // Masked so a drained FIFO shows zeros rather than stale entries.
  assign head_dat = empty ? '0 : mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: one-cold column drive, frame debounce, per-key press/release events.
// Events reach key_valid one cycle after being pushed; a full FIFO drops events and sets overflow.
module keypad_matrix_scanner
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int CLK_DIV         = 50000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4,
  localparam int CODE_W         = clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_overflow,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  output logic              key_release,
  output logic              any_key,
  output logic              overflow
);

  localparam int NKEYS  = ROWS * COLS;
  localparam int TICK_W = clog2(CLK_DIV);
  localparam int COL_W  = clog2(COLS);
  localparam int EVT_W  = evt_width(CODE_W);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLK_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
  localparam logic [CODE_W-1:0] IDX_LAST   = CODE_W'(NKEYS - 1);
  localparam logic [3:0]        STABLE_MAX = 4'(DEBOUNCE_FRAMES);
  localparam logic [COLS-1:0]   COL_ONE    = COLS'(1);

  state_t            state_q, state_d;
  logic [ROWS-1:0]   row_s1_q, row_s2_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [COLS-1:0]   col_n_q, col_n_d;
  logic [NKEYS-1:0]  frame_q, frame_d, prev_q, prev_d, deb_q, deb_d, diff_q, diff_d;
  logic [3:0]        stable_q, stable_d, stable_new;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic              any_key_q, overflow_q, overflow_d;
  logic [NKEYS-1:0]  frame_full;
  logic              tick, frame_done, start_emit;
  logic              push, pop, drop, fifo_full, fifo_empty;
  logic [EVT_W-1:0]  push_dat, head_dat;

  // Frame as it will look once the current column's sample is merged in.
  always_comb begin
    frame_full = frame_q;
    frame_full[col_q * ROWS +: ROWS] = ~row_s2_q;
  end

  assign tick       = (tick_q == TICK_LAST);
  assign frame_done = (state_q == SCAN) && enable && tick && (col_q == COL_LAST);
  assign stable_new = (frame_full != prev_q)    ? 4'd1 :
                      (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
  assign start_emit = frame_done && (stable_new == STABLE_MAX) && (frame_full != deb_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SCAN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (start_emit) state_d = EMIT;
      EMIT:    if (idx_q == IDX_LAST) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    push     = (state_q == EMIT) && diff_q[idx_q];
    push_dat = {~frame_q[idx_q], idx_q};
  end

  // Scan/debounce datapath; EMIT freezes the scan so the column drive stays put.
  always_comb begin
    tick_d   = tick_q;
    col_d    = col_q;
    col_n_d  = col_n_q;
    frame_d  = frame_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    deb_d    = deb_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    if (state_q == EMIT) begin
      deb_d[idx_q] = frame_q[idx_q];
      idx_d        = idx_q + 1'b1;
    end else if (!enable) begin
      tick_d   = '0;
      col_d    = '0;
      stable_d = '0;
      col_n_d  = '1;
    end else begin
      tick_d = tick ? '0 : tick_q + 1'b1;
      if (tick) begin
        frame_d = frame_full;
        col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end
      col_n_d = ~(COL_ONE << col_d);
      if (frame_done) begin
        stable_d = stable_new;
        prev_d   = frame_full;
        if (start_emit) begin
          diff_d = frame_full ^ deb_q;
          idx_d  = '0;
        end
      end
    end
  end

  assign pop        = ~fifo_empty & key_ready;
  assign drop       = push & fifo_full & ~pop;
  assign overflow_d = drop | (overflow_q & ~clear_overflow);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q   <= '1;
      row_s2_q   <= '1;
      tick_q     <= '0;
      col_q      <= '0;
      col_n_q    <= '1;
      frame_q    <= '0;
      prev_q     <= '0;
      stable_q   <= '0;
      deb_q      <= '0;
      diff_q     <= '0;
      idx_q      <= '0;
      any_key_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      row_s1_q   <= row_n;
      row_s2_q   <= row_s1_q;
      tick_q     <= tick_d;
      col_q      <= col_d;
      col_n_q    <= col_n_d;
      frame_q    <= frame_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      deb_q      <= deb_d;
      diff_q     <= diff_d;
      idx_q      <= idx_d;
      any_key_q  <= |deb_q;
      overflow_q <= overflow_d;
    end
  end

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_rdy  (key_ready),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign col_n                  = col_n_q;
  assign key_valid              = ~fifo_empty;
  assign {key_release, key_code} = head_dat;
  assign any_key                = any_key_q;
  assign overflow               = overflow_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a key-matrix model drives row_n from col_n, and a
// scoreboard queue of expected events is checked by a monitor whenever an event is popped.
module tb_keypad_matrix_scanner;

  localparam int ROWS = 4, COLS = 3, CLK_DIV = 16, DEB = 2, FIFO_DEPTH = 4, CODE_W = 4;
  localparam int FRAME = COLS * CLK_DIV;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic clear_overflow = 1'b0;
  logic key_ready = 1'b1;
  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col_n;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_release, any_key, overflow;

  logic [ROWS*COLS-1:0] keys = '0;
  logic [CODE_W:0]      sb[$];
  logic [CODE_W:0]      exp_evt;
  int compared = 0;
  int mismatched = 0;
  int ev_count = 0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV),
    .DEBOUNCE_FRAMES(DEB), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_overflow(clear_overflow),
    .row_n(row_n), .col_n(col_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_code(key_code), .key_release(key_release), .any_key(any_key), .overflow(overflow)
  );

  // Pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!col_n[c] && keys[c*ROWS + r]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (reset && key_valid && key_ready) begin
      ev_count++;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got rel=%0d code=%0d, required no event", key_release, key_code);
      end else begin
        exp_evt = sb.pop_front();
        if ({key_release, key_code} !== exp_evt) begin
          mismatched++;
          $display("FAIL event: got rel=%0d code=%0d, required rel=%0d code=%0d",
                   key_release, key_code, exp_evt[CODE_W], exp_evt[CODE_W-1:0]);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    wait_cycles(3);
    compared++; if (col_n !== {COLS{1'b1}}) begin mismatched++; $display("FAIL reset_col_n: got %b, required %b", col_n, {COLS{1'b1}}); end
    compared++; if (key_valid !== 1'b0) begin mismatched++; $display("FAIL reset_key_valid: got %b, required 0", key_valid); end
    compared++; if ({key_release, key_code} !== 5'd0) begin mismatched++; $display("FAIL reset_head: got %0h, required 0", {key_release, key_code}); end
    compared++; if (any_key !== 1'b0) begin mismatched++; $display("FAIL reset_any_key: got %b, required 0", any_key); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    reset = 1'b1;
    wait_cycles(2);
    compared++; if (col_n !== 3'b110) begin mismatched++; $display("FAIL scan_start_col_n: got %b, required 110", col_n); end
  endtask

  task automatic test_single_press();
    bit ok;
    int n;
    keys[9] = 1'b1;
    sb.push_back({1'b0, 4'd9});
    wait_drain(4 * FRAME, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL press9_timeout: got %0d pending, required 0", sb.size()); end
    wait_cycles(2);
    compared++; if (any_key !== 1'b1) begin mismatched++; $display("FAIL press9_any_key: got %b, required 1", any_key); end
    n = ev_count;
    wait_cycles(3 * FRAME);
    compared++; if (ev_count !== n) begin mismatched++; $display("FAIL held_no_repeat: got %0d events, required 0", ev_count - n); end
  endtask

  task automatic test_release();
    bit ok;
    keys[9] = 1'b0;
    sb.push_back({1'b1, 4'd9});
    wait_drain(4 * FRAME, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL release9_timeout: got %0d pending, required 0", sb.size()); end
    wait_cycles(2);
    compared++; if (any_key !== 1'b0) begin mismatched++; $display("FAIL release9_any_key: got %b, required 0", any_key); end
  endtask

  task automatic test_chatter();
    int n;
    bit seen_any;
    n = ev_count;
    seen_any = 1'b0;
    // Half-period of 16 clocks makes the key's sample flip every frame.
    for (int i = 0; i < 30; i++) begin
      keys[9] = ~keys[9];
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (any_key) seen_any = 1'b1;
      end
    end
    keys[9] = 1'b0;
    wait_cycles(4 * FRAME);
    compared++; if (ev_count !== n) begin mismatched++; $display("FAIL chatter_events: got %0d, required 0", ev_count - n); end
    compared++; if (seen_any !== 1'b0) begin mismatched++; $display("FAIL chatter_any_key: got %b, required 0", seen_any); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int n;
    n = ev_count;
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    sb.push_back({1'b0, 4'd0});
    sb.push_back({1'b0, 4'd5});
    wait_drain(4 * FRAME, ok);
    compared++; if (!ok || ev_count - n != 2) begin mismatched++; $display("FAIL two_press: got %0d events, required 2", ev_count - n); end
    keys[0] = 1'b0;
    keys[5] = 1'b0;
    sb.push_back({1'b1, 4'd0});
    sb.push_back({1'b1, 4'd5});
    wait_drain(4 * FRAME, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL two_release_timeout: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_overflow();
    bit ok;
    int n;
    int codes [6] = '{1, 2, 4, 7, 10, 11};
    key_ready = 1'b0;
    foreach (codes[i]) keys[codes[i]] = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back({1'b0, 4'(codes[i])});
    n = ev_count;
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (overflow === 1'b1) ok = 1'b1;
    end
    compared++; if (!ok) begin mismatched++; $display("FAIL overflow_set: got %b, required 1", overflow); end
    wait_cycles(5);
    compared++; if (key_valid !== 1'b1 || key_code !== 4'd1) begin mismatched++; $display("FAIL stalled_head: got v=%b code=%0d, required v=1 code=1", key_valid, key_code); end
    key_ready = 1'b1;
    wait_drain(10, ok);
    compared++; if (!ok || ev_count - n != 4) begin mismatched++; $display("FAIL overflow_drain: got %0d events, required 4", ev_count - n); end
    wait_cycles(2);
    compared++; if (key_valid !== 1'b0 || overflow !== 1'b1) begin mismatched++; $display("FAIL after_drain: got v=%b ovf=%b, required v=0 ovf=1", key_valid, overflow); end
    clear_overflow = 1'b1;
    wait_cycles(1);
    clear_overflow = 1'b0;
    wait_cycles(1);
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL overflow_clear: got %b, required 0", overflow); end
    compared++; if (any_key !== 1'b1) begin mismatched++; $display("FAIL dropped_still_debounced: got %b, required 1", any_key); end
    foreach (codes[i]) begin
      keys[codes[i]] = 1'b0;
      sb.push_back({1'b1, 4'(codes[i])});
    end
    wait_drain(4 * FRAME, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL six_release_timeout: got %0d pending, required 0", sb.size()); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL six_release_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_reset_during_emit();
    bit ok;
    key_ready = 1'b0;
    keys[3] = 1'b1;
    keys[6] = 1'b1;
    keys[8] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) ok = 1'b1;
    end
    compared++; if (!ok) begin mismatched++; $display("FAIL emit_start: got key_valid=%b, required 1", key_valid); end
    reset = 1'b0;
    sb.delete();
    wait_cycles(1);
    compared++; if (col_n !== {COLS{1'b1}}) begin mismatched++; $display("FAIL mid_reset_col_n: got %b, required %b", col_n, {COLS{1'b1}}); end
    compared++; if (key_valid !== 1'b0 || {key_release, key_code} !== 5'd0) begin mismatched++; $display("FAIL mid_reset_head: got v=%b head=%0h, required v=0 head=0", key_valid, {key_release, key_code}); end
    compared++; if (any_key !== 1'b0 || overflow !== 1'b0) begin mismatched++; $display("FAIL mid_reset_flags: got any=%b ovf=%b, required 0 0", any_key, overflow); end
    reset = 1'b1;
    key_ready = 1'b1;
    sb.push_back({1'b0, 4'd3});
    sb.push_back({1'b0, 4'd6});
    sb.push_back({1'b0, 4'd8});
    wait_drain(4 * FRAME, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL rereport_timeout: got %0d pending, required 0", sb.size()); end
    wait_cycles(2);
    compared++; if (any_key !== 1'b1) begin mismatched++; $display("FAIL rereport_any_key: got %b, required 1", any_key); end
    keys[3] = 1'b0;
    keys[6] = 1'b0;
    keys[8] = 1'b0;
    sb.push_back({1'b1, 4'd3});
    sb.push_back({1'b1, 4'd6});
    sb.push_back({1'b1, 4'd8});
    wait_drain(4 * FRAME, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL final_release_timeout: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_chatter();
    test_simultaneous();
    test_overflow();
    test_reset_during_emit();
    wait_cycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised matrix-keypad controller for a ROWS x COLS active-low key matrix. Drives one column low at a time, synchronises and samples the rows, and debounces whole scan frames. Emits separate press and release events for every key, including simultaneous keys, into an event FIFO. The consumer drains the FIFO through a valid/ready interface. Next-generation replacement for the fixed 3x3 single-key scanner that sits between the board keypad header and game logic.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column outputs (2..8)
CLK_DIV, 50000, clk cycles per scan tick; must be >= ROWS*COLS+4
DEBOUNCE_FRAMES, 3, consecutive identical full frames required before state is accepted (1..15)
FIFO_DEPTH, 4, event FIFO entries, power of two (2..16)
CODE_W, derived, clog2(ROWS*COLS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
enable  in  1  scanning enable
clear_overflow  in  1  synchronous pulse, clears overflow flag
row_n  in  ROWS  raw row lines, low = pressed key in driven column
col_n  out  COLS  column drive, one-cold during scan
key_valid  out  1  FIFO head valid
key_ready  in  1  consumer accepts head
key_code  out  CODE_W  head key index = col*ROWS + row
key_release  out  1  head event type: 0 = press, 1 = release
any_key  out  1  OR of debounced key state
overflow  out  1  sticky: event dropped because FIFO full

Behaviour:
- Reset (async, active-low) clears the following, mid-operation included. Discards FIFO contents and any partial emit.
  - col_n = all ones; key_valid/key_code/key_release/any_key/overflow = 0.
  - Tick counter, column pointer and frame register = 0; stable count = 0; debounced state = 0.
- row_n passes through a 2-flop synchroniser, then is inverted (pressed = 1).
- Tick counter counts 0..CLK_DIV-1; a tick fires when it wraps.
- On each tick in SCAN:
  - Store synchronised rows into frame bits [col*ROWS +: ROWS] for the current column.
  - Advance the column pointer, wrapping COLS-1 to 0.
  - Drive col_n for the new column in the same cycle.
- A full frame is complete when the pointer wraps. At frame completion:
  - If frame == previous frame, stable count increments, saturating at DEBOUNCE_FRAMES. Otherwise stable count = 1.
  - previous frame <= frame.
  - If stable count reaches DEBOUNCE_FRAMES and frame != debounced state, capture diff = frame XOR debounced and enter EMIT.
- FSM states:
  - SCAN: normal scanning.
  - EMIT: walks index 0..ROWS*COLS-1, one index per clk.
    - For each set diff bit, push {release = ~frame[i], code = i}, then update debounced[i].
    - Tick counter and column are held; col_n keeps its drive.
    - Returns to SCAN after the last index; the tick counter resumes from its held value.
- enable low: col_n = all ones, tick counter and column pointer forced to 0, stable count = 0. The debounced state is kept, the FIFO still drains, and EMIT in progress completes first.
- FIFO behaviour:
  - Show-ahead: a push into an empty FIFO gives key_valid = 1 on the next cycle (1-cycle latency).
  - Pop on key_valid & key_ready. Head fields stay stable while key_valid & ~key_ready.
- Full FIFO:
  - A push without a simultaneous pop is dropped and sets overflow; debounced[i] is still updated.
  - A push with a simultaneous pop is accepted.
- Overflow clearing: clear_overflow clears overflow unless a drop happens in the same cycle; the drop wins.
- any_key is registered from the debounced state.
- Pressed keys on multiple rows or columns are reported individually; no ghost suppression.

Decomposition:
- Shared keypad package/header: function clog2, event record width (CODE_W+1), FSM state encodings SCAN/EMIT.
- Sub-module keypad_event_fifo (parametrised DEPTH, WIDTH): synchronous FIFO with show-ahead, full/empty flags, push/pop, and same-cycle push+pop when full.
- Scanner, debouncer and emitter stay in the top module.

Test Plan:
Shared bench config: ROWS=4, COLS=3, CLK_DIV=16, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4, key_ready=1 unless stated.
1. Key at row 1, col 2 held low -> one event code=9, key_release=0, any_key=1, within 4 frames (4*3*16 clk). No further events while held.
2. Same key chatters with a period < 1 frame for 10 frames, then opens -> no events, any_key stays 0.
3. Press code 9, then release -> press event followed by release event code=9 key_release=1, any_key=0.
4. Codes 0 and 5 pressed in the same frame -> two events, code 0 then 5, both press, on consecutive FIFO entries.
5. key_ready=0, six distinct presses -> 4 events kept in order, overflow=1. Set key_ready=1 -> drains 4. Pulse clear_overflow -> overflow=0.
6. Assert reset during EMIT with 3 pending diffs, then release -> all outputs at reset values, key_valid=0. Held keys are re-reported as presses after the debounce time.
